// File: rtl/nf_cc_pkg.sv
// Shared types for the cross-connect responder: FSM states, captured request, wait limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nf_cc_pkg;

  // Largest wait-state count the 4-bit wait counter can express.
  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } cc_state_e;

  // Copy of the request taken in the capture cycle. The responder works from
  // this copy for the rest of the transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
  } cc_req_t;

endpackage

// File: rtl/nf_cc_resp_if.sv
// Cross-connect request bus: master drives addr/wd/we/req, slave returns rd/req_ack/err/busy.
// Latency: n/a (wires only).
// Backpressure: master holds req until req_ack; busy shows the slave is mid-transaction.
interface nf_cc_resp_if;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        we;
  logic        req;
  logic [31:0] rd;
  logic        req_ack;
  logic        err;
  logic        busy;

  modport master (
    output addr, wd, we, req,
    input  rd, req_ack, err, busy
  );

  modport slave (
    input  addr, wd, we, req,
    output rd, req_ack, err, busy
  );
endinterface

// File: rtl/nf_cc_ram.sv
// Single-port 32-bit word RAM, 2**ADDR_W deep, synchronous write and registered read.
// Latency: read data appears the cycle after re_i; write lands at the edge with we_i.
// Backpressure: none, accepts one access per cycle.
module nf_cc_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [31:0]       wd_i,
  input  logic              re_i,
  output logic [31:0]       rd_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rd_q;

  // Storage is deliberately not reset; only the read register follows re_i.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wd_i;
    end
    if (re_i) begin
      rd_q <= mem_q[addr_i];
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/nf_cc_resp.sv
// Cross-connect slave: captures one request, waits WAIT_CYC cycles, accesses the RAM, pulses req_ack.
// Latency: req_ack is high WAIT_CYC+1 cycles after the capture cycle.
// Backpressure: requests are ignored while busy; a held req is captured again in the IDLE cycle after ACK.
module nf_cc_resp
  import nf_cc_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          WAIT_CYC  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  nf_cc_resp_if.slave bus
);

  // Elaboration-time parameter checks.
  if (WAIT_CYC < 0 || WAIT_CYC > WAIT_MAX) begin : g_bad_wait_cyc
    $error("nf_cc_resp: WAIT_CYC=%0d outside 0..%0d", WAIT_CYC, WAIT_MAX);
  end
  if (BASE_ADDR[ADDR_W+1:0] != '0) begin : g_bad_base_addr
    $error("nf_cc_resp: BASE_ADDR=%h not aligned to the RAM window size", BASE_ADDR);
  end

  // Value the wait counter starts from; unused when there are no wait states.
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  // Address lies inside the RAM window when the bits above the word index match the base.
  function automatic logic in_window(input logic [31:0] a);
    return a[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  endfunction

  // Word index within the window; the byte-lane bits drop out of the shift.
  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return ADDR_W'((a - BASE_ADDR) >> 2);
  endfunction

  cc_state_e   state_q;
  logic [3:0]  cnt_q;
  cc_req_t     req_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] rd_q;

  logic              req_in_win;
  logic              to_ack;
  logic              cur_we;
  logic              ram_re;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdat;
  logic [31:0]       rd_ack;

  assign req_in_win = in_window(req_q.addr);

  // RAM control: the read is launched in the cycle before ACK so the registered
  // RAM output is ready in the ACK cycle. With no wait states that cycle is the
  // capture cycle, so the live bus address is used while IDLE.
  always_comb begin
    ram_addr = word_idx(req_q.addr);
    cur_we   = req_q.we;
    to_ack   = 1'b0;
    if (state_q == IDLE) begin
      ram_addr = word_idx(bus.addr);
      cur_we   = bus.we;
      to_ack   = bus.req && (WAIT_CYC == 0);
    end else if (state_q == WAIT) begin
      to_ack   = (cnt_q == 4'd0);
    end
    ram_re = to_ack && !cur_we;
    ram_we = (state_q == ACK) && req_q.we && req_in_win;
  end

  // Read data presented in the ACK cycle: zero outside the window, the RAM word
  // for an in-window read, and the previous value for an in-window write.
  always_comb begin
    rd_ack = rd_q;
    if (!req_in_win) begin
      rd_ack = 32'd0;
    end else if (!req_q.we) begin
      rd_ack = ram_rdat;
    end
  end

  // Transaction FSM with registered ack/err/busy; reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            req_q.addr <= bus.addr;
            req_q.wd   <= bus.wd;
            req_q.we   <= bus.we;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_LOAD;
            if (WAIT_CYC == 0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= !in_window(bus.addr);
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            err_q   <= !req_in_win;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rd_q    <= rd_ack;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  nf_cc_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .wd_i   (req_q.wd),
    .re_i   (ram_re),
    .rd_o   (ram_rdat)
  );

  // rd follows the fresh value during ACK and holds it until the next ack.
  assign bus.rd      = (state_q == ACK) ? rd_ack : rd_q;
  assign bus.req_ack = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule
